sort_loader: RTL and testbench

Upstream feeder for the bubble-sort engine. Accepts a stream of data words over a valid/ready handshake and writes them into the sort memory at addresses 1..n. Writes the element count n to address 0, then pulses the engine's `run`. Tracks the engine's two `done_rev` pulses (one at sort start, one at sort end) to report completion, and hands the memory write port to the engine while it runs.

---
 rtl/sort_loader_pkg.sv | 16 +
 rtl/sort_loader_sat_counter.sv | 37 +++
 rtl/sort_loader.sv | 168 ++++++++++++++++
 tb/tb_sort_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sort_loader_pkg.sv
// Shared definitions for the sort loader: FSM state encoding and the header address.
package sort_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_HDR      = 3'd2,
        ST_START    = 3'd3,
        ST_WAIT_BEG = 3'd4,
        ST_WAIT_END = 3'd5,
        ST_DONE     = 3'd6
    } state_e;

    localparam int unsigned HDR_ADDR = 0;

endpackage

// File: rtl/sort_loader_sat_counter.sv
// Saturating up-counter: clear forces the base to zero, enable adds one unless already at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;
    logic [W-1:0] base_s;

    // Next value; clear and enable together yields 1 so a fresh batch can start counting at once.
    always_comb begin
        base_s = clr_i ? '0 : q_q;
        if (en_i && (base_s != {W{1'b1}})) begin
            q_d = base_s + W'(1);
        end else begin
            q_d = base_s;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/sort_loader.sv
// Loads a word stream into the sort memory, writes the count header, starts and tracks the sort engine.
// Optional SORT_LOADER_CYCCNT_EN adds a sort_cycles output measuring sort duration.
module sort_loader
    import sort_loader_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          mem_own,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          run,
    input  logic          done_rev,
    output logic          busy,
    output logic          ovf,
    output logic          sort_done,
    output logic [AW-1:0] n_out
`ifdef SORT_LOADER_CYCCNT_EN
    ,
    output logic [31:0]   sort_cycles
`endif
);

    state_e        state_q, state_d;
    logic          ovf_q, ovf_d;
    logic [AW-1:0] n_out_q, n_out_d;
    logic [AW-1:0] cnt_s;
    logic          cnt_clr_s, cnt_en_s;
    logic          accept_s, drop_s;

    assign in_ready = rstn & ((state_q == ST_IDLE) | (state_q == ST_LOAD));
    assign accept_s = in_valid & in_ready;

    sat_counter #(.W(AW)) u_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (cnt_clr_s),
        .en_i  (cnt_en_s),
        .q_o   (cnt_s)
    );

    // Next-state and output decode; the write port is combinational so a beat is stored on its accept edge.
    always_comb begin
        state_d   = state_q;
        ovf_d     = ovf_q;
        n_out_d   = n_out_q;
        mem_own   = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_din   = '0;
        run       = 1'b0;
        sort_done = 1'b0;
        cnt_clr_s = 1'b0;
        cnt_en_s  = 1'b0;
        drop_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_addr = AW'(1);
                mem_din  = in_data;
                mem_we   = accept_s;
                if (accept_s) begin
                    ovf_d     = 1'b0;
                    cnt_clr_s = 1'b1;
                    cnt_en_s  = 1'b1;
                    state_d   = in_last ? ST_HDR : ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                drop_s   = (cnt_s == {AW{1'b1}});
                mem_addr = cnt_s + AW'(1);
                mem_din  = in_data;
                mem_we   = accept_s & ~drop_s;
                if (accept_s) begin
                    ovf_d    = ovf_q | drop_s;
                    cnt_en_s = ~drop_s;
                    state_d  = in_last ? ST_HDR : ST_LOAD;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_HDR: begin
                mem_we   = 1'b1;
                mem_addr = AW'(HDR_ADDR);
                mem_din  = DW'(cnt_s);
                n_out_d  = cnt_s;
                state_d  = ST_START;
            end
            ST_START: begin
                mem_own = 1'b0;
                run     = 1'b1;
                state_d = ST_WAIT_BEG;
            end
            ST_WAIT_BEG: begin
                mem_own = 1'b0;
                state_d = done_rev ? ST_WAIT_END : ST_WAIT_BEG;
            end
            ST_WAIT_END: begin
                mem_own = 1'b0;
                state_d = done_rev ? ST_DONE : ST_WAIT_END;
            end
            ST_DONE: begin
                mem_own   = 1'b0;
                sort_done = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, overflow flag and latched element count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            ovf_q   <= 1'b0;
            n_out_q <= '0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            n_out_q <= n_out_d;
        end
    end

    assign busy  = (state_q != ST_IDLE);
    assign ovf   = ovf_q;
    assign n_out = n_out_q;

`ifdef SORT_LOADER_CYCCNT_EN
    logic        cyc_clr_s, cyc_en_s;
    logic [31:0] cyc_cnt_s;
    logic [31:0] sort_cycles_q;

    assign cyc_clr_s = (state_q == ST_START);
    assign cyc_en_s  = (state_q == ST_WAIT_BEG) | (state_q == ST_WAIT_END);

    sat_counter #(.W(32)) u_cyc (
        .clk   (clk),
        .rstn  (rstn),
        .clr_i (cyc_clr_s),
        .en_i  (cyc_en_s),
        .q_o   (cyc_cnt_s)
    );

    // Capture the sort duration while in DONE; the counter is frozen there.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sort_cycles_q <= 32'd0;
        end else if (state_q == ST_DONE) begin
            sort_cycles_q <= cyc_cnt_s;
        end else begin
            sort_cycles_q <= sort_cycles_q;
        end
    end

    assign sort_cycles = sort_cycles_q;
`endif

endmodule

// File: tb/tb_sort_loader.sv
// Drives a default (AW=8) and a small (AW=2) loader in lockstep; writes are scoreboarded per instance.
module tb_sort_loader;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rstn, in_valid, in_last, done_rev;
    logic [DW-1:0] in_data;

    logic          in_ready, mem_own, mem_we, run, busy, ovf, sort_done;
    logic [7:0]    mem_addr, n_out;
    logic [DW-1:0] mem_din;

    logic          s_in_ready, s_mem_own, s_mem_we, s_run, s_busy, s_ovf, s_sort_done;
    logic [1:0]    s_mem_addr, s_n_out;
    logic [DW-1:0] s_mem_din;
`ifdef SORT_LOADER_CYCCNT_EN
    logic [31:0]   sort_cycles, s_sort_cycles;
`endif

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t big_q[$];
    wr_t small_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  last_cyc = 0;
    int  done_cnt = 0;
    int  done_before = 0;

    sort_loader #(.DW(DW), .AW(8)) u_dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .mem_own(mem_own), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .run(run), .done_rev(done_rev), .busy(busy), .ovf(ovf),
        .sort_done(sort_done), .n_out(n_out)
`ifdef SORT_LOADER_CYCCNT_EN
        , .sort_cycles(sort_cycles)
`endif
    );

    sort_loader #(.DW(DW), .AW(2)) u_small (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .in_last(in_last), .mem_own(s_mem_own), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
        .mem_din(s_mem_din), .run(s_run), .done_rev(done_rev), .busy(s_busy), .ovf(s_ovf),
        .sort_done(s_sort_done), .n_out(s_n_out)
`ifdef SORT_LOADER_CYCCNT_EN
        , .sort_cycles(s_sort_cycles)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write monitors: every write must match the head of the instance's expected-write queue.
    always @(negedge clk) begin
        wr_t e;
        if (sort_done === 1'b1) done_cnt++;
        if (mem_we === 1'b1) begin
            check("big_wr_expected", 32'(big_q.size() != 0), 32'd1);
            check("big_wr_own", 32'(mem_own), 32'd1);
            if (big_q.size() != 0) begin
                e = big_q.pop_front();
                check("big_wr_addr", 32'(mem_addr), 32'(e.addr));
                check("big_wr_data", mem_din, e.data);
            end
        end
        if (s_mem_we === 1'b1) begin
            check("small_wr_expected", 32'(small_q.size() != 0), 32'd1);
            check("small_wr_own", 32'(s_mem_own), 32'd1);
            if (small_q.size() != 0) begin
                e = small_q.pop_front();
                check("small_wr_addr", 32'(s_mem_addr), 32'(e.addr));
                check("small_wr_data", s_mem_din, e.data);
            end
        end
    end

    // k is the 0-based beat index; the small instance keeps only the first three words.
    task automatic push_beat(input int k, input logic [31:0] d);
        big_q.push_back({8'(k + 1), d});
        if (k < 3) small_q.push_back({8'(k + 1), d});
    endtask

    task automatic push_hdr(input int n);
        big_q.push_back({8'd0, 32'(n)});
        small_q.push_back({8'd0, 32'((n > 3) ? 3 : n)});
    endtask

    task automatic send_beat(input int k, input logic [31:0] d, input logic last);
        int budget;
        budget = 0;
        push_beat(k, d);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("accept", 32'(in_ready), 32'd1);
        last_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_run();
        int budget;
        budget = 0;
        @(negedge clk);
        while (!run && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("run_seen", 32'(run), 32'd1);
        check("run_latency", 32'(cyc), 32'(last_cyc + 2));
    endtask

    // Called at the negedge of the run cycle R; done_rev pulses in cycles R+beg and R+fin.
    task automatic do_sort(input int beg, input int fin, input int n);
        repeat (beg) @(posedge clk);
        #1;
        check("run_one_cycle", 32'(run), 32'd0);
        check("in_ready_sorting", 32'(in_ready), 32'd0);
        check("mem_own_sorting", 32'(mem_own), 32'd0);
        check("busy_sorting", 32'(busy), 32'd1);
        done_rev = 1'b1;
        @(posedge clk); #1;
        done_rev = 1'b0;
        check("sort_done_early", 32'(sort_done), 32'd0);
        repeat (fin - beg - 1) @(posedge clk);
        #1;
        done_rev = 1'b1;
        @(posedge clk); #1;
        done_rev = 1'b0;
        check("sort_done", 32'(sort_done), 32'd1);
        check("small_sort_done", 32'(s_sort_done), 32'd1);
        check("n_out", 32'(n_out), 32'(n));
        check("small_n_out", 32'(s_n_out), 32'((n > 3) ? 3 : n));
        @(posedge clk); #1;
        check("sort_done_pulse", 32'(sort_done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
`ifdef SORT_LOADER_CYCCNT_EN
        check("sort_cycles", sort_cycles, 32'(fin));
        check("small_sort_cycles", s_sort_cycles, 32'(fin));
`endif
    endtask

    initial begin
        logic [31:0] words [5];
        words = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5};
        rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = 32'd0; done_rev = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_small_in_ready", 32'(s_in_ready), 32'd0);
        check("rst_mem_own", 32'(mem_own), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_run", 32'(run), 32'd0);
        check("rst_small_run", 32'(s_run), 32'd0);
        check("rst_sort_done", 32'(sort_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_small_busy", 32'(s_busy), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_n_out", 32'(n_out), 32'd0);
`ifdef SORT_LOADER_CYCCNT_EN
        check("rst_sort_cycles", sort_cycles, 32'd0);
`endif
        rstn = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Five-word batch: the small instance overflows after three words.
        for (int i = 0; i < 5; i++) send_beat(i, words[i], (i == 4));
        push_hdr(5);
        wait_run();
        do_sort(3, 40, 5);
        check("ovf_big", 32'(ovf), 32'd0);
        check("ovf_small", 32'(s_ovf), 32'd1);

        // Single-word batch; a following beat is held valid through the whole sort.
        send_beat(0, 32'd42, 1'b1);
        push_hdr(1);
        check("ovf_small_cleared", 32'(s_ovf), 32'd0);
        in_valid = 1'b1;
        in_data  = 32'd77;
        in_last  = 1'b1;
        push_beat(0, 32'd77);
        wait_run();
        do_sort(1, 2, 1);
        check("held_accept", 32'(in_ready), 32'd1);
        last_cyc = cyc;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        push_hdr(1);
        wait_run();
        do_sort(2, 6, 1);

        // Reset while waiting for the end pulse.
        send_beat(0, 32'd100, 1'b0);
        send_beat(1, 32'd200, 1'b1);
        push_hdr(2);
        wait_run();
        @(posedge clk); #1;
        done_rev = 1'b1;
        @(posedge clk); #1;
        done_rev = 1'b0;
        done_before = done_cnt;
        rstn = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_mem_own", 32'(mem_own), 32'd1);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_n_out", 32'(n_out), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        done_rev = 1'b1;
        @(posedge clk); #1;
        done_rev = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_done", 32'(done_cnt), 32'(done_before));
        check("midrst_idle", 32'(busy), 32'd0);

        send_beat(0, 32'd11, 1'b0);
        send_beat(1, 32'd22, 1'b0);
        send_beat(2, 32'd33, 1'b1);
        push_hdr(3);
        wait_run();
        do_sort(2, 5, 3);
        check("ovf_small_3", 32'(s_ovf), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("big_q_drained", 32'(big_q.size()), 32'd0);
        check("small_q_drained", 32'(small_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
